// File: rtl/mult_unit_if.sv
// mult_unit_if: execute-stage multiply request and HI/LO result bundle.
interface mult_unit_if #(parameter int WIDTH = 32);
  logic aluormultE;
  logic signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic prodv;
  logic busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output aluormultE, signedE, srcaE, srcbE, input prodv, busy, hi, lo);
  modport slave(input aluormultE, signedE, srcaE, srcbE, output prodv, busy, hi, lo);
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add MULT/MULTU into HI/LO, one multiplier bit per cycle.
// Optional MULT_EARLY_TERM_EN finishes as soon as no set multiplier bits remain.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} multState;
  multState state, nextState;
  logic [WIDTH-1:0] mcand, mplr, acc, absA, absB, hi, lo;
  logic neg, lastStep;
  logic [CW-1:0] count;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] stepProd, finalProd;
  always_comb begin
    absA = (bus.signedE & bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    absB = (bus.signedE & bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;
    sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    stepProd = {sum, mplr[WIDTH-1:1]};
`ifdef MULT_EARLY_TERM_EN
    // unprocessed multiplier bits sit in mplr[LAST-count:0]; bit 0 is consumed this cycle
    lastStep = (count == LAST) || (((mplr & ({WIDTH{1'b1}} >> count)) >> 1) == '0);
    finalProd = stepProd >> (LAST - count);
`else
    lastStep = count == LAST;
    finalProd = stepProd;
`endif
    nextState = (state == IDLE) ? (bus.aluormultE ? BUSY : IDLE)
              : (state == BUSY) ? (!bus.aluormultE ? IDLE : lastStep ? DONE : BUSY)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      mplr <= '0;
      acc <= '0;
      neg <= 1'b0;
      count <= '0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE && bus.aluormultE) begin
      mcand <= absA;
      mplr <= absB;
      acc <= '0;
      count <= '0;
      neg <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
    end else if (state == BUSY && bus.aluormultE) begin
      acc <= sum[WIDTH:1];
      mplr <= {sum[0], mplr[WIDTH-1:1]};
      count <= count + 1'b1;
      if (lastStep) {hi, lo} <= neg ? -finalProd : finalProd;
    end
  end
  assign bus.prodv = state == DONE;
  assign bus.busy = state == BUSY;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: scoreboard bench for mult_unit; the driver queues expected HI/LO and prodv cycle,
// a negedge monitor pops and compares on every prodv.
module tb_mult_unit;
  localparam int W = 32;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int cyc;
  } expT;
  typedef struct {
    logic s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit b2b;
  } vecT;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic prevProdv = 1'b0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;
  expT sb[$];
  expT monE;
  vecT vec[12];
  mult_unit_if #(.WIDTH(W)) bus();
  mult_unit #(.WIDTH(W)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic int latency(input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int h;
    m = (s && b[W-1]) ? -b : b;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i;
    return EARLY ? h + 1 : W;
  endfunction
  always @(negedge clk) begin
    if (bus.prodv) begin
      check("prodv_pulse_width", 64'(prevProdv), 64'd0);
      check("busy_with_prodv", 64'(bus.busy), 64'd0);
      if (sb.size() == 0) check("unexpected_prodv", 64'd1, 64'd0);
      else begin
        monE = sb.pop_front();
        check("hi", 64'(bus.hi), 64'(monE.hi));
        check("lo", 64'(bus.lo), 64'(monE.lo));
        check("prodv_cycle", 64'(cyc), 64'(monE.cyc));
      end
    end
    prevProdv <= bus.prodv;
  end
  task automatic runMult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input bit afterDone);
    expT e;
    bit seen;
    bus.signedE = s;
    bus.srcaE = a;
    bus.srcbE = b;
    bus.aluormultE = 1'b1;
    e.hi = eh;
    e.lo = el;
    e.cyc = cyc + (afterDone ? 2 : 1) + latency(s, b);
    sb.push_back(e);
    lastHi = eh;
    lastLo = el;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.prodv) seen = 1'b1;
      else if (i == 2) begin
        bus.srcaE = $urandom;
        bus.srcbE = $urandom;
      end
    end
    if (!seen) check("prodv_timeout", 64'd0, 64'd1);
  endtask
  task automatic idleCycle();
    bus.aluormultE = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic s;
    logic [W-1:0] a, b;
    logic [63:0] p;
    bit anyProdv;
    vec = '{
      '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0},
      '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0},
      '{1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1},
      '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
      '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0},
      '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
      '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0},
      '{1'b1, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}
    };
    reset = 1'b1;
    bus.aluormultE = 1'b0;
    bus.signedE = 1'b0;
    bus.srcaE = '0;
    bus.srcbE = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_prodv", 64'(bus.prodv), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      runMult(vec[i].s, vec[i].a, vec[i].b, vec[i].hi, vec[i].lo, vec[i].b2b);
      if (i == 11 || !vec[i+1].b2b) idleCycle();
    end
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      p = s ? $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}) : {{W{1'b0}}, a} * {{W{1'b0}}, b};
      runMult(s, a, b, p[63:32], p[31:0], 1'b0);
      idleCycle();
    end
    runMult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    idleCycle();
    bus.signedE = 1'b0;
    bus.srcaE = 32'h0000_0005;
    bus.srcbE = 32'hFFFF_FFFF;
    bus.aluormultE = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    bus.aluormultE = 1'b0;
    anyProdv = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.prodv) anyProdv = 1'b1;
    end
    check("abort_no_prodv", 64'(anyProdv), 64'd0);
    check("abort_busy_after", 64'(bus.busy), 64'd0);
    check("abort_hi_kept", 64'(bus.hi), 64'(lastHi));
    check("abort_lo_kept", 64'(bus.lo), 64'(lastLo));
    bus.signedE = 1'b1;
    bus.srcaE = 32'h0000_0009;
    bus.srcbE = 32'hFFFF_FFFF;
    bus.aluormultE = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_hi", 64'(bus.hi), 64'd0);
    check("midreset_lo", 64'(bus.lo), 64'd0);
    check("midreset_prodv", 64'(bus.prodv), 64'd0);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    bus.aluormultE = 1'b0;
    @(negedge clk);
    runMult(1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
    idleCycle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
